ram_port_arbiter: RTL and testbench

- Shares the single-port block RAM (blram) between two requesters: port 0 is the FBCPU memory interface, port 1 is the program loader / debug monitor.
- Arbitrates per cycle with round-robin fairness and an optional port-1 burst lock bounded by a starvation limit.
- Routes the RAM's one-cycle-latency read data back to the requester that issued the read.
- Sits between FBCPU/loader and blram; drives blram i_we, i_addr and i_ram_data_in, and receives o_ram_data_out.

---
 rtl/ram_port_arbiter_if.sv | 46 ++++
 rtl/ram_port_arbiter.sv | 109 ++++++++++
 tb/tb_ram_port_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the two RAM requesters, the arbiter and the blram port.
// slave is the arbiter's view; master is the requester/RAM-model side.
interface ram_port_arbiter_if #(
   parameter int unsigned ADDRESS_WIDTH = 6,
   parameter int unsigned DATA_WIDTH    = 10
);
   logic                     m0_req;
   logic                     m0_we;
   logic [ADDRESS_WIDTH-1:0] m0_addr;
   logic [DATA_WIDTH-1:0]    m0_wdata;
   logic                     m0_gnt;
   logic                     m0_rvalid;
   logic [DATA_WIDTH-1:0]    m0_rdata;

   logic                     m1_req;
   logic                     m1_we;
   logic [ADDRESS_WIDTH-1:0] m1_addr;
   logic [DATA_WIDTH-1:0]    m1_wdata;
   logic                     m1_lock;
   logic                     m1_gnt;
   logic                     m1_rvalid;
   logic [DATA_WIDTH-1:0]    m1_rdata;

   logic                     ram_we;
   logic [ADDRESS_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0]    ram_wdata;
   logic [DATA_WIDTH-1:0]    ram_rdata;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      output m0_gnt, m0_rvalid, m0_rdata,
      input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
      output m1_gnt, m1_rvalid, m1_rdata,
      output ram_we, ram_addr, ram_wdata,
      input  ram_rdata
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      input  m0_gnt, m0_rvalid, m0_rdata,
      output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  ram_we, ram_addr, ram_wdata,
      output ram_rdata
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter for the single-port blram, with a bounded
// port-1 burst lock and tagged return of the one-cycle-latency read data.
module ram_port_arbiter #(
   parameter int unsigned ADDRESS_WIDTH = 6,
   parameter int unsigned DATA_WIDTH    = 10,
   parameter int unsigned MAX_LOCK      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   ram_port_arbiter_if.slave    bus
);
   localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(MAX_LOCK);

   typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lockState_t;

   lockState_t       lockState, nextState;
   logic [CNT_W-1:0] lockCnt, nextCnt;
   logic             lastWinner, nextWinner;
   logic [1:0]       rdPending, nextPending;
   logic             gnt0, gnt1;
   logic             lockOpen;

   // Grant, RAM mux and next-state logic
   always_comb begin
      gnt0          = 1'b0;
      gnt1          = 1'b0;
      nextState     = lockState;
      nextCnt       = lockCnt;
      nextWinner    = lastWinner;
      nextPending   = 2'b00;
      lockOpen      = (lockState == LOCKED) && (lockCnt < LOCK_LIMIT);
      bus.ram_we    = 1'b0;
      bus.ram_addr  = bus.m0_addr;
      bus.ram_wdata = bus.m0_wdata;

      if (!rst) begin
         if (bus.m0_req && !bus.m1_req) begin
            gnt0 = 1'b1;
         end else if (!bus.m0_req && bus.m1_req) begin
            gnt1 = 1'b1;
         end else if (bus.m0_req && bus.m1_req) begin
            // A live lock under its limit overrides round-robin
            if (lockOpen)        gnt1 = 1'b1;
            else if (lastWinner) gnt0 = 1'b1;
            else                 gnt1 = 1'b1;
         end
      end

      if (rst) begin
         bus.ram_addr  = ADDRESS_WIDTH'(0);
         bus.ram_wdata = DATA_WIDTH'(0);
      end else if (gnt1) begin
         bus.ram_we    = bus.m1_we;
         bus.ram_addr  = bus.m1_addr;
         bus.ram_wdata = bus.m1_wdata;
      end else if (gnt0) begin
         bus.ram_we    = bus.m0_we;
      end

      if (gnt0) nextWinner = 1'b0;
      if (gnt1) nextWinner = 1'b1;
      nextPending = {gnt1 & ~bus.m1_we, gnt0 & ~bus.m0_we};

      case (lockState)
         UNLOCKED: begin
            if (gnt1 && bus.m1_lock) begin
               nextState = LOCKED;
               nextCnt   = CNT_W'(1);
            end
         end
         LOCKED: begin
            if (!bus.m1_req || !bus.m1_lock || gnt0) begin
               nextState = UNLOCKED;
               nextCnt   = CNT_W'(0);
            end else if (gnt1 && (lockCnt < LOCK_LIMIT)) begin
               nextCnt   = lockCnt + CNT_W'(1);
            end
         end
         default: begin
            nextState = UNLOCKED;
            nextCnt   = CNT_W'(0);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lockState  <= UNLOCKED;
         lockCnt    <= CNT_W'(0);
         lastWinner <= 1'b1;
         rdPending  <= 2'b00;
      end else begin
         lockState  <= nextState;
         lockCnt    <= nextCnt;
         lastWinner <= nextWinner;
         rdPending  <= nextPending;
      end
   end

   assign bus.m0_gnt = gnt0;
   assign bus.m1_gnt = gnt1;

   // Reset kills a read already in flight as well as new ones
   assign bus.m0_rvalid = rdPending[0] & ~rst;
   assign bus.m1_rvalid = rdPending[1] & ~rst;
   assign bus.m0_rdata  = bus.ram_rdata;
   assign bus.m1_rdata  = bus.ram_rdata;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: per-cycle grant/RAM-drive checks plus
// a read-return scoreboard drained by an independent monitor.
module tb_ram_port_arbiter;
   localparam int unsigned AW = 6;
   localparam int unsigned DW = 10;

   typedef struct {
      int port;
      int data;
   } exp_t;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   int   pendExp;
   exp_t sbQ[$];
   logic [DW-1:0] mem [0:(1<<AW)-1];

   ram_port_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ram_port_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // blram behavioural model: write-first not needed, read data one cycle later
   always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
   end

   task automatic check(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r0, input logic w0, input int a0, input int d0,
                        input logic r1, input logic w1, input int a1, input int d1,
                        input logic l1);
      bus.m0_req   = r0;
      bus.m0_we    = w0;
      bus.m0_addr  = AW'(a0);
      bus.m0_wdata = DW'(d0);
      bus.m1_req   = r1;
      bus.m1_we    = w1;
      bus.m1_addr  = AW'(a1);
      bus.m1_wdata = DW'(d1);
      bus.m1_lock  = l1;
   endtask

   // One cycle: check combinational grant/RAM drive mid-cycle, queue read return
   task automatic step(input string nm, input int eg0, input int eg1, input int ewe,
                       input int eaddr, input int ewdata, input int pport, input int pdata);
      exp_t e;
      @(negedge clk);
      check({nm, " m0_gnt"},    int'(bus.m0_gnt), eg0);
      check({nm, " m1_gnt"},    int'(bus.m1_gnt), eg1);
      check({nm, " ram_we"},    int'(bus.ram_we), ewe);
      check({nm, " ram_addr"},  int'(bus.ram_addr), eaddr);
      check({nm, " ram_wdata"}, int'(bus.ram_wdata), ewdata);
      check({nm, " rvalid"},    int'({bus.m1_rvalid, bus.m0_rvalid}), rst ? 0 : pendExp);
      pendExp = 0;
      if (pport >= 0) begin
         e.port = pport;
         e.data = pdata;
         sbQ.push_back(e);
         pendExp = (pport == 0) ? 1 : 2;
      end
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every rvalid must match the oldest expected read
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.m0_rvalid || bus.m1_rvalid) begin
            check("rvalid onehot", int'(bus.m0_rvalid & bus.m1_rvalid), 0);
            if (sbQ.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected rvalid: got m0=%0d m1=%0d expected none",
                        bus.m0_rvalid, bus.m1_rvalid);
            end else begin
               e = sbQ.pop_front();
               check("rd port", bus.m1_rvalid ? 1 : 0, e.port);
               check("rd data", bus.m0_rvalid ? int'(bus.m0_rdata) : int'(bus.m1_rdata), e.data);
            end
         end
      end
   end

   initial begin
      tests   = 0;
      fails   = 0;
      pendExp = 0;
      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      mem[52] = DW'(50);
      mem[10] = DW'(100);
      mem[20] = DW'(200);
      mem[33] = DW'(333);

      // Reset: grants and RAM drive forced low even with both ports requesting writes
      rst = 1'b1;
      drive(1, 1, 7, 9, 1, 1, 8, 3, 0);
      @(posedge clk);
      #1;
      step("reset", 0, 0, 0, 0, 0, -1, 0);
      step("reset2", 0, 0, 0, 0, 0, -1, 0);
      rst = 1'b0;

      // Port 0 reads 52 alone for three cycles
      drive(1, 0, 52, 0, 0, 0, 0, 0, 0);
      repeat (3) step("t1 rd", 1, 0, 0, 52, 0, 0, 50);
      drive(0, 0, 52, 0, 0, 0, 0, 0, 0);
      step("t1 idle", 0, 0, 0, 52, 0, -1, 0);
      step("t1 idle2", 0, 0, 0, 52, 0, -1, 0);

      // Contention from reset alternates m0,m1,...
      rst = 1'b1;
      drive(1, 0, 10, 0, 1, 0, 20, 0, 0);
      step("t2 rst", 0, 0, 0, 0, 0, -1, 0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) step("t2 m0", 1, 0, 0, 10, 0, 0, 100);
         else            step("t2 m1", 0, 1, 0, 20, 0, 1, 200);
      end
      drive(0, 0, 10, 0, 0, 0, 20, 0, 0);
      step("t2 idle", 0, 0, 0, 10, 0, -1, 0);

      // Port 1 writes 15 to 52, then port 0 reads it back
      drive(0, 0, 10, 0, 1, 1, 52, 15, 0);
      step("t3 wr", 0, 1, 1, 52, 15, -1, 0);
      drive(1, 0, 52, 0, 0, 0, 0, 0, 0);
      step("t3 rd", 1, 0, 0, 52, 0, 0, 15);
      drive(0, 0, 52, 0, 0, 0, 0, 0, 0);
      step("t3 idle", 0, 0, 0, 52, 0, -1, 0);

      // Locked burst: 8 grants to m1, forced m0, then m1 re-locks
      drive(1, 0, 10, 0, 1, 0, 33, 0, 1);
      for (int i = 0; i < 8; i++) step("t4 lock", 0, 1, 0, 33, 0, 1, 333);
      step("t4 limit", 1, 0, 0, 10, 0, 0, 100);
      step("t4 relock", 0, 1, 0, 33, 0, 1, 333);

      // Lock drops when m1_req falls; next contention is plain round-robin
      drive(0, 0, 10, 0, 0, 0, 33, 0, 1);
      step("t5 drop", 0, 0, 0, 10, 0, -1, 0);
      drive(1, 0, 10, 0, 1, 0, 33, 0, 1);
      step("t5 rr", 1, 0, 0, 10, 0, 0, 100);

      // Reset right after a read grant suppresses its return
      drive(1, 0, 52, 0, 0, 0, 0, 0, 0);
      step("t6 rd", 1, 0, 0, 52, 0, -1, 0);
      rst = 1'b1;
      drive(1, 0, 52, 0, 1, 0, 33, 0, 0);
      step("t6 rst", 0, 0, 0, 0, 0, -1, 0);
      rst = 1'b0;
      step("t6 rr", 1, 0, 0, 52, 0, 0, 15);
      drive(0, 0, 52, 0, 0, 0, 0, 0, 0);
      step("t6 idle", 0, 0, 0, 52, 0, -1, 0);
      step("t6 idle2", 0, 0, 0, 52, 0, -1, 0);

      check("scoreboard drained", sbQ.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
